mul_hilo_unit: RTL

//  Issue/writeback stage wrapped around the iterative Booth multiplier core (en/sign/operands in, done pulse + 2N-bit product out).

---
 rtl/mul_hilo_unit_if.sv | 32 +++
 rtl/mul_hilo_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mul_hilo_unit_if.sv
// Request/writeback and multiplier-core signal bundle for mul_hilo_unit.
// slave is the unit's view; master is the view of whatever drives it
// (execute stage plus multiplier core).
interface mul_hilo_unit_if #(
    parameter int unsigned DATA_BITS = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [2:0]               req_op;
    logic [DATA_BITS-1:0]     req_a;
    logic [DATA_BITS-1:0]     req_b;
    logic                     busy;
    logic                     done;
    logic [DATA_BITS-1:0]     hi;
    logic [DATA_BITS-1:0]     lo;
    logic                     mul_en;
    logic                     mul_sign;
    logic [DATA_BITS-1:0]     mul_a;
    logic [DATA_BITS-1:0]     mul_b;
    logic                     mul_done;
    logic [2*DATA_BITS-1:0]   mul_product;

    modport slave (
        input  req_valid, req_op, req_a, req_b, mul_done, mul_product,
        output req_ready, busy, done, hi, lo, mul_en, mul_sign, mul_a, mul_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, mul_done, mul_product,
        input  req_ready, busy, done, hi, lo, mul_en, mul_sign, mul_a, mul_b
    );
endinterface

// File: rtl/mul_hilo_unit.sv
// Issue/writeback stage around an iterative multiplier core. Accepts
// MULT/MADD/MSUB (signed and unsigned) and MTHI/MTLO, starts the core,
// waits for its done pulse and folds the product into the HI/LO pair.
module mul_hilo_unit #(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    mul_hilo_unit_if.slave    bus
);
    localparam int unsigned PROD_BITS = 2 * DATA_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_ADD,
        ACC_SUB
    } acc_t;

    state_t                 r_state;
    acc_t                   r_acc;
    logic [DATA_BITS-1:0]   r_hi;
    logic [DATA_BITS-1:0]   r_lo;
    logic [DATA_BITS-1:0]   r_mul_a;
    logic [DATA_BITS-1:0]   r_mul_b;
    logic                   r_mul_sign;
    logic [PROD_BITS-1:0]   r_prod;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_is_move;
    acc_t                   w_acc_sel;
    logic [PROD_BITS-1:0]   w_hilo;
    logic [PROD_BITS-1:0]   w_next_hilo;

    assign bus.req_ready = (r_state == S_IDLE) && !rst;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.mul_en    = (r_state == S_ISSUE);
    assign bus.mul_sign  = r_mul_sign;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;

    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_is_move = (bus.req_op[2:1] == 2'b11);
    assign w_hilo    = {r_hi, r_lo};

    // Decode accumulate mode from the opcode and form the modular HI/LO update
    always_comb begin
        w_acc_sel = ACC_NONE;
        case (bus.req_op[2:1])
            2'b01:   w_acc_sel = ACC_ADD;
            2'b10:   w_acc_sel = ACC_SUB;
            default: w_acc_sel = ACC_NONE;
        endcase

        w_next_hilo = r_prod;
        case (r_acc)
            ACC_ADD: w_next_hilo = w_hilo + r_prod;
            ACC_SUB: w_next_hilo = w_hilo - r_prod;
            default: w_next_hilo = r_prod;
        endcase
    end

    // Control FSM plus HI/LO, operand and done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= ACC_NONE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_sign <= 1'b0;
            r_prod     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_move) begin
                            if (bus.req_op[0]) begin
                                r_lo <= bus.req_a;
                            end else begin
                                r_hi <= bus.req_a;
                            end
                            r_done <= 1'b1;
                        end else begin
                            r_mul_a    <= bus.req_a;
                            r_mul_b    <= bus.req_b;
                            r_mul_sign <= ~bus.req_op[0];
                            r_acc      <= w_acc_sel;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mul_done) begin
                        r_prod  <= bus.mul_product;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    {r_hi, r_lo} <= w_next_hilo;
                    r_done       <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
